// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM link: capture FSM state encoding and the
// idle timeout that separates a very long period from a dead input.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_ARM   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_STUCK = 3'd4
  } pwm_state_e;

  // One clock beyond the longest legal period of a top_width-bit generator.
  function automatic int pwm_timeout(input int top_width);
    return (1 << top_width) + 1;
  endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Synchronizes an asynchronous level and produces registered one-cycle
// rise/fall pulses from the synchronized level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Recovers the top/compare pair of an incoming PWM waveform and flags a
// constant-level input as stuck.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int TOP_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_pwm,
  output logic [TOP_WIDTH-1:0] o_top,
  output logic                 o_top_valid,
  output logic [TOP_WIDTH:0]   o_compare,
  output logic                 o_compare_valid,
  output logic                 o_stuck,
  output logic                 o_level
);

  localparam int CW = TOP_WIDTH + 1;
  localparam logic [CW-1:0] TIMEOUT = CW'(pwm_timeout(TOP_WIDTH));
  localparam logic [CW-1:0] PRIMED  = CW'(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // Stuck high reports a compare one above top, i.e. 100% duty.
  function automatic logic [CW-1:0] stuck_compare(input logic lvl,
                                                  input logic [TOP_WIDTH-1:0] top);
    return lvl ? ({1'b0, top} + CW'(1)) : '0;
  endfunction

  logic lvl, rise, fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_pwm),
    .o_level (lvl),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  pwm_state_e           state_q;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        high_q;
  logic [TOP_WIDTH-1:0] rep_top_q;
  logic [CW-1:0]        rep_cmp_q;
  logic                 report_q;
  logic [TOP_WIDTH-1:0] top_q;
  logic [CW-1:0]        cmp_q;
  logic                 valid_q, stuck_q, level_q;
  logic                 timeout, stuck_go, stuck_lvl;

  assign count_d = rise ? CW'(1) : sat_inc(count_q);
  assign timeout = (count_q >= TIMEOUT);

  // An edge arriving on the timeout cycle takes priority over declaring stuck.
  always_comb begin
    stuck_go  = 1'b0;
    stuck_lvl = 1'b0;
    case (state_q)
      ST_SYNC: if (timeout && lvl && !rise) begin stuck_go = 1'b1; stuck_lvl = 1'b1; end
      ST_ARM:  if (timeout && !rise)        stuck_go = 1'b1;
      ST_HIGH: if (timeout && !fall)        begin stuck_go = 1'b1; stuck_lvl = 1'b1; end
      ST_LOW:  if (timeout && !rise)        stuck_go = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_SYNC;
      count_q   <= '0;
      high_q    <= '0;
      rep_top_q <= '0;
      rep_cmp_q <= '0;
      report_q  <= 1'b0;
      top_q     <= '0;
      cmp_q     <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      report_q <= 1'b0;
      valid_q  <= 1'b0;
      case (state_q)
        // Leave SYNC only once the synchronizer and edge flops reflect the real input.
        ST_SYNC:  if (!lvl && count_q >= PRIMED) state_q <= ST_ARM;
                  else if (stuck_go)             state_q <= ST_STUCK;
        ST_ARM:   if (rise)          state_q <= ST_HIGH;
                  else if (stuck_go) state_q <= ST_STUCK;
        ST_HIGH:  if (fall) begin
                    high_q  <= count_q;
                    state_q <= ST_LOW;
                  end else if (stuck_go) state_q <= ST_STUCK;
        ST_LOW:   if (rise) begin
                    rep_top_q <= TOP_WIDTH'(count_q - CW'(1));
                    rep_cmp_q <= high_q;
                    report_q  <= 1'b1;
                    state_q   <= ST_HIGH;
                  end else if (stuck_go) state_q <= ST_STUCK;
        ST_STUCK: if (rise)      state_q <= ST_HIGH;
                  else if (fall) state_q <= ST_ARM;
        default:  state_q <= ST_SYNC;
      endcase
      if (report_q) begin
        top_q   <= rep_top_q;
        cmp_q   <= rep_cmp_q;
        stuck_q <= 1'b0;
        valid_q <= 1'b1;
      end else if (stuck_go && !stuck_q) begin
        stuck_q <= 1'b1;
        level_q <= stuck_lvl;
        cmp_q   <= stuck_compare(stuck_lvl, top_q);
        valid_q <= 1'b1;
      end
    end
  end

  assign o_top           = top_q;
  assign o_compare       = cmp_q;
  assign o_top_valid     = valid_q;
  assign o_compare_valid = valid_q;
  assign o_stuck         = stuck_q;
  assign o_level         = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a reference PWM generator and hand-driven
// waveforms, with hand-computed expected reports.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       man;
  logic       gen_en;
  logic       gen_pwm = 1'b0;
  logic       i_pwm;
  int         gen_top, gen_cmp;
  int         gc = 0, top_l = 0, cmp_l = 0;

  logic [7:0] o_top;
  logic       o_top_valid;
  logic [8:0] o_compare;
  logic       o_compare_valid;
  logic       o_stuck;
  logic       o_level;

  int checks = 0;
  int errors = 0;
  int nstrobe = 0;
  logic vld_mis = 1'b0;
  logic seen43 = 1'b0;
  int n, n0, k, bad;

  always #5 clk = ~clk;

  assign i_pwm = gen_en ? gen_pwm : man;

  pwm_capture dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_pwm           (i_pwm),
    .o_top           (o_top),
    .o_top_valid     (o_top_valid),
    .o_compare       (o_compare),
    .o_compare_valid (o_compare_valid),
    .o_stuck         (o_stuck),
    .o_level         (o_level)
  );

  // Reference generator: top/compare latched at each period boundary.
  always @(negedge clk) begin
    if (!gen_en) begin
      gc      <= 0;
      gen_pwm <= 1'b0;
    end else if (gc == 0) begin
      top_l   <= gen_top;
      cmp_l   <= gen_cmp;
      gen_pwm <= (gen_cmp != 0);
      gc      <= (gen_top == 0) ? 0 : 1;
    end else begin
      gen_pwm <= (gc < cmp_l);
      gc      <= (gc >= top_l) ? 0 : gc + 1;
    end
  end

  always @(negedge clk) begin
    if (o_top_valid) nstrobe <= nstrobe + 1;
    if (o_top_valid != o_compare_valid) vld_mis <= 1'b1;
    if (o_top_valid && o_top == 8'd43) seen43 <= 1'b1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_top_valid && cyc < max_cyc);
    chk("strobe_seen", o_top_valid, 1);
  endtask

  initial begin
    rst = 1'b1; man = 1'b0; gen_en = 1'b0; gen_top = 99; gen_cmp = 25;
    repeat (3) @(negedge clk);
    chk("rst_top", o_top, 0);
    chk("rst_cmp", o_compare, 0);
    chk("rst_vld", o_top_valid, 0);
    chk("rst_stuck", o_stuck, 0);
    chk("rst_level", o_level, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    gen_en = 1'b1;

    // top=99 compare=25 steady stream
    wait_strobe(300, n);
    chk("b_top", o_top, 99);
    chk("b_cmp", o_compare, 25);
    chk("b_stuck", o_stuck, 0);
    wait_strobe(200, n);
    chk("b_interval", n, 100);
    chk("b_top2", o_top, 99);
    chk("b_cmp2", o_compare, 25);

    // compare change mid-stream
    gen_cmp = 60;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(200, n);
      if (!(o_compare == 9'd25 || o_compare == 9'd60) || o_top != 8'd99) bad++;
    end
    chk("c_values", bad, 0);
    chk("c_final", o_compare, 60);

    // shortest period
    gen_top = 1; gen_cmp = 1;
    repeat (4) wait_strobe(200, n);
    wait_strobe(10, n);
    chk("d_interval", n, 2);
    chk("d_top", o_top, 1);
    chk("d_cmp", o_compare, 1);

    // constant low
    gen_top = 99; gen_cmp = 25;
    repeat (4) wait_strobe(300, n);
    chk("e_pre_top", o_top, 99);
    gen_cmp = 0;
    wait_strobe(400, n);
    chk("e_time", n, 256);
    chk("e_stuck", o_stuck, 1);
    chk("e_level", o_level, 0);
    chk("e_cmp", o_compare, 0);
    chk("e_top", o_top, 99);
    @(posedge clk); n0 = nstrobe;
    repeat (600) @(negedge clk);
    @(posedge clk);
    chk("e_once", nstrobe - n0, 0);
    gen_cmp = 25;
    wait_strobe(400, n);
    chk("e_clr_stuck", o_stuck, 0);
    chk("e_clr_top", o_top, 99);
    chk("e_clr_cmp", o_compare, 25);

    // constant high
    gen_cmp = 200;
    k = 0;
    do begin
      wait_strobe(400, n);
      k++;
    end while (!o_stuck && k < 3);
    chk("f_stuck", o_stuck, 1);
    chk("f_level", o_level, 1);
    chk("f_cmp", o_compare, 100);
    chk("f_top", o_top, 99);
    @(posedge clk); n0 = nstrobe;
    repeat (600) @(negedge clk);
    @(posedge clk);
    chk("f_once", nstrobe - n0, 0);

    // reset during a high phase
    gen_cmp = 25;
    k = 0;
    while (i_pwm && k < 400) begin @(posedge clk); k++; end
    while (!i_pwm && k < 800) begin @(posedge clk); k++; end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("g_top", o_top, 0);
    chk("g_cmp", o_compare, 0);
    chk("g_stuck", o_stuck, 0);
    chk("g_level", o_level, 0);
    chk("g_vld", o_top_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_strobe(400, n);
    chk("g_wait", int'(n > 150), 1);
    chk("g_top2", o_top, 99);
    chk("g_cmp2", o_compare, 25);
    chk("g_stuck2", o_stuck, 0);

    // hand-driven period 300, high 100
    rst = 1'b1; gen_en = 1'b0; man = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk); n0 = nstrobe;
    @(negedge clk);
    fork
      begin
        man = 1'b1; repeat (100) @(negedge clk);
        man = 1'b0; repeat (200) @(negedge clk);
        man = 1'b1; repeat (100) @(negedge clk);
        man = 1'b0; repeat (200) @(negedge clk);
      end
      begin
        wait_strobe(400, n);
      end
    join
    chk("h_time", n, 261);
    chk("h_stuck", o_stuck, 1);
    chk("h_level", o_level, 0);
    chk("h_cmp", o_compare, 0);
    chk("h_top", o_top, 0);
    @(posedge clk);
    chk("h_count", nstrobe - n0, 1);
    chk("h_no43", seen43, 0);

    // rise lands on the timeout cycle: edge wins
    rst = 1'b1; man = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = nstrobe;
    repeat (254) @(negedge clk);
    man = 1'b1; repeat (25) @(negedge clk);
    man = 1'b0; repeat (75) @(negedge clk);
    man = 1'b1;
    wait_strobe(20, n);
    chk("i_latency", n, 5);
    chk("i_stuck", o_stuck, 0);
    chk("i_top", o_top, 99);
    chk("i_cmp", o_compare, 25);
    @(posedge clk);
    chk("i_count", nstrobe - n0, 1);

    // one clock later the timeout wins
    rst = 1'b1; man = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (255) @(negedge clk);
    man = 1'b1;
    wait_strobe(10, n);
    chk("j_time", n, 3);
    chk("j_stuck", o_stuck, 1);
    chk("j_level", o_level, 0);

    chk("vld_coinc", vld_mis, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
